// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
//   Shared definitions for the ALU scratch-memory port master:
//   bus widths, memory read/write encoding on mem_read, the controller
//   state enum and a small address-increment helper (wraps mod 2**AW).
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

    localparam int AW   = 5;   // memory address width
    localparam int DW   = 32;  // data width
    localparam int LENW = 3;   // burst length field width (beats-1)

    // mem_read encoding: the memory writes whenever this line is low
    localparam logic MEM_RD = 1'b1;
    localparam logic MEM_WR = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_ADDR   = 3'd1,
        ST_RD_WAIT   = 3'd2,
        ST_RD_RSP    = 3'd3,
        ST_WR_DATA   = 3'd4,
        ST_WR_SETUP  = 3'd5,
        ST_WR_STROBE = 3'd6
    } state_e;

    // Next burst address; natural overflow gives the 31 -> 0 wrap.
    function automatic logic [AW-1:0] addr_next(input logic [AW-1:0] addr);
        return addr + AW'(1);
    endfunction

endpackage

// File: rtl/mem_port_master_if.sv
// ---------------------------------------------------------------------------
// mem_port_master_if
//   Bundles the command, write-data, read-response and memory-side signals
//   of the scratch-memory port master.
//   master modport : the controller (drives ready/valid outputs and memory)
//   slave  modport : the datapath/memory side
// ---------------------------------------------------------------------------
interface mem_port_master_if;
    import mem_ctrl_pkg::*;

    // command channel
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [AW-1:0]   req_addr;
    logic [LENW-1:0] req_len;
    // write beat channel
    logic            wd_valid;
    logic            wd_ready;
    logic [DW-1:0]   wd_data;
    // read response channel
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic            rsp_last;
    // write completion
    logic            wr_done;
    // memory side
    logic [AW-1:0]   mem_address;
    logic [DW-1:0]   mem_in;
    logic            mem_read;
    logic [DW-1:0]   mem_out;

    modport master (
        input  req_valid, req_write, req_addr, req_len,
        output req_ready,
        input  wd_valid, wd_data,
        output wd_ready,
        output rsp_valid, rsp_data, rsp_last,
        input  rsp_ready,
        output wr_done,
        output mem_address, mem_in, mem_read,
        input  mem_out
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len,
        input  req_ready,
        output wd_valid, wd_data,
        input  wd_ready,
        input  rsp_valid, rsp_data, rsp_last,
        output rsp_ready,
        input  wr_done,
        input  mem_address, mem_in, mem_read,
        output mem_out
    );

endinterface

// File: rtl/mem_rd_delay.sv
// ---------------------------------------------------------------------------
// mem_rd_delay
//   Read-latency timer. Loaded when the read address is being registered;
//   capture is high during the last of RD_LAT wait cycles, i.e. at the edge
//   where mem_out has been valid for RD_LAT cycles after mem_address changed.
//   Ports:
//     clk, rst_n : clock / async active-low reset
//     start      : load the timer (controller is in its address phase)
//     capture    : sample mem_out at the coming edge
// ---------------------------------------------------------------------------
module mem_rd_delay #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic capture
);

    localparam int             LAT  = (RD_LAT < 1) ? 1 : RD_LAT;
    localparam int             CW   = $clog2(LAT + 1);
    localparam logic [CW-1:0]  LOAD = CW'(LAT);
    localparam logic [CW-1:0]  ONE  = CW'(1);
    localparam logic [CW-1:0]  ZERO = {CW{1'b0}};

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next value of the countdown: reload on start, otherwise run down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = LOAD;
        end else if (cnt_q != ZERO) begin
            cnt_d = cnt_q - ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Countdown register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign capture = (cnt_q == ONE);

endmodule

// File: rtl/mem_port_master.sv
// ---------------------------------------------------------------------------
// mem_port_master
//   Initiator for the 32x32 ALU scratch memory. Accepts single or burst
//   (1..8 beat) read/write commands, returns read beats over a valid/ready
//   response channel and pulses wr_done after the last write strobe.
//   The memory writes whenever mem_read is low, so every write is staged:
//   address/data are registered, held for a setup cycle with mem_read high,
//   and only then is mem_read dropped for exactly one cycle.
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset (mem_read returns high at once)
//     bus    : mem_port_master_if.master (command, write data, read
//              response, wr_done and the memory address/data/read lines)
//   Parameter RD_LAT: cycles from mem_address change to mem_out sampling.
// ---------------------------------------------------------------------------
module mem_port_master
    import mem_ctrl_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_port_master_if.master     bus
);

    localparam logic [LENW-1:0] LEN_ZERO = {LENW{1'b0}};
    localparam logic [LENW-1:0] LEN_ONE  = LENW'(1);

    state_e          state_q,       state_d;
    logic [AW-1:0]   addr_q,        addr_d;
    logic [LENW-1:0] cnt_q,         cnt_d;
    logic            req_ready_q,   req_ready_d;
    logic            wd_ready_q,    wd_ready_d;
    logic            rsp_valid_q,   rsp_valid_d;
    logic            rsp_last_q,    rsp_last_d;
    logic [DW-1:0]   rsp_data_q,    rsp_data_d;
    logic            wr_done_q,     wr_done_d;
    logic [AW-1:0]   mem_address_q, mem_address_d;
    logic [DW-1:0]   mem_in_q,      mem_in_d;
    logic            mem_read_q,    mem_read_d;
    logic            rd_capture_s;

    mem_rd_delay #(
        .RD_LAT (RD_LAT)
    ) u_rd_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (state_q == ST_RD_ADDR),
        .capture (rd_capture_s)
    );

    // Next-state logic and next values of all registered outputs.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        mem_address_d = mem_address_q;
        mem_in_d      = mem_in_q;
        rsp_data_d    = rsp_data_q;
        wr_done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    addr_d  = bus.req_addr;
                    cnt_d   = bus.req_len;
                    state_d = bus.req_write ? ST_WR_DATA : ST_RD_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                mem_address_d = addr_q;
                state_d       = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (rd_capture_s) begin
                    rsp_data_d = bus.mem_out;
                    state_d    = ST_RD_RSP;
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_RSP: begin
                if (bus.rsp_ready && rsp_valid_q) begin
                    if (cnt_q == LEN_ZERO) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_next(addr_q);
                        cnt_d   = cnt_q - LEN_ONE;
                        state_d = ST_RD_ADDR;
                    end
                end else begin
                    state_d = ST_RD_RSP;
                end
            end
            ST_WR_DATA: begin
                // Address and data are registered together here so they are
                // already stable for the whole setup cycle.
                if (bus.wd_valid && wd_ready_q) begin
                    mem_address_d = addr_q;
                    mem_in_d      = bus.wd_data;
                    state_d       = ST_WR_SETUP;
                end else begin
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_STROBE;
            end
            ST_WR_STROBE: begin
                // addr_q moves on, but mem_address only reloads at the next
                // write-data handshake, so the memory lines stay put.
                if (cnt_q == LEN_ZERO) begin
                    wr_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    addr_d  = addr_next(addr_q);
                    cnt_d   = cnt_q - LEN_ONE;
                    state_d = ST_WR_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake and strobe outputs follow the state being entered so the
        // registered versions line up with the state register.
        req_ready_d = (state_d == ST_IDLE);
        wd_ready_d  = (state_d == ST_WR_DATA);
        rsp_valid_d = (state_d == ST_RD_RSP);
        rsp_last_d  = (state_d == ST_RD_RSP) && (cnt_d == LEN_ZERO);
        mem_read_d  = (state_d == ST_WR_STROBE) ? MEM_WR : MEM_RD;
    end

    // State and output registers; reset parks the memory in read/hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= {AW{1'b0}};
            cnt_q         <= LEN_ZERO;
            req_ready_q   <= 1'b0;
            wd_ready_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_last_q    <= 1'b0;
            rsp_data_q    <= {DW{1'b0}};
            wr_done_q     <= 1'b0;
            mem_address_q <= {AW{1'b0}};
            mem_in_q      <= {DW{1'b0}};
            mem_read_q    <= MEM_RD;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            req_ready_q   <= req_ready_d;
            wd_ready_q    <= wd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_last_q    <= rsp_last_d;
            rsp_data_q    <= rsp_data_d;
            wr_done_q     <= wr_done_d;
            mem_address_q <= mem_address_d;
            mem_in_q      <= mem_in_d;
            mem_read_q    <= mem_read_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.wd_ready    = wd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_last    = rsp_last_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.wr_done     = wr_done_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_in      = mem_in_q;
    assign bus.mem_read    = mem_read_q;

endmodule

// File: tb/tb_mem_port_master.sv
// ---------------------------------------------------------------------------
// tb_mem_port_master
//   Scoreboard bench: expected read beats are queued when a read command is
//   issued and popped when the DUT hands a beat over. A behavioural 32x32
//   memory writes whenever mem_read is low; monitors count strobes and
//   wr_done pulses and flag unstable write lines or unstable held responses.
// ---------------------------------------------------------------------------
module tb_mem_port_master;
    import mem_ctrl_pkg::*;

    localparam int BOUND = 200;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    mem_port_master_if bus();

    mem_port_master #(.RD_LAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem     [0:31];
    logic [DW-1:0] exp_mem [0:31];
    logic          preloaded = 1'b0;
    beat_t         sb [$];
    beat_t         b;

    int n_cmp = 0;
    int n_err = 0;
    int strobes = 0, wr_dones = 0, extra_beats = 0;
    int viol_stable = 0, viol_hold = 0, viol_excl = 0;

    logic          prev_read  = 1'b1;
    logic [AW-1:0] prev_addr  = '0;
    logic [DW-1:0] prev_in    = '0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_rdata = '0;
    logic          prev_last  = 1'b0;

    assign bus.mem_out = mem[bus.mem_address];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model, invariant monitors and scoreboard pop, sampled mid-cycle.
    always @(negedge clk) begin
        if (!preloaded) begin
            for (int k = 0; k < 32; k++) mem[k] = DW'(k);
            preloaded = 1'b1;
        end
        if (bus.mem_read === 1'b0) begin
            strobes++;
            mem[bus.mem_address] = bus.mem_in;
            if (prev_read === 1'b0 || bus.mem_address !== prev_addr || bus.mem_in !== prev_in)
                viol_stable++;
        end
        if (bus.wr_done === 1'b1) begin
            wr_dones++;
            if (bus.rsp_valid === 1'b1) viol_excl++;
        end
        if (prev_stall && bus.rsp_valid === 1'b1 &&
            (bus.rsp_data !== prev_rdata || bus.rsp_last !== prev_last))
            viol_hold++;
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                extra_beats++;
            end else begin
                b = sb.pop_front();
                check("rsp_data", bus.rsp_data, b.data);
                check("rsp_last", {31'd0, bus.rsp_last}, {31'd0, b.last});
            end
        end
        prev_read  = bus.mem_read;
        prev_addr  = bus.mem_address;
        prev_in    = bus.mem_in;
        prev_stall = (bus.rsp_valid === 1'b1) && (bus.rsp_ready !== 1'b1);
        prev_rdata = bus.rsp_data;
        prev_last  = bus.rsp_last;
    end

    function automatic logic sel_sig(input int sel);
        case (sel)
            0:       return bus.req_ready;
            1:       return bus.wd_ready;
            default: return bus.rsp_valid;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input string tag);
        int n = 0;
        while (sel_sig(sel) !== 1'b1 && n < BOUND) begin
            @(posedge clk); #1; n++;
        end
        check(tag, {31'd0, n < BOUND}, 32'd1);
    endtask

    task automatic send_req(input logic wr, input logic [AW-1:0] a, input logic [LENW-1:0] len);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_len   = len;
        wait_sig(0, "req_ready_wait");
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [LENW-1:0] len, input int stall);
        logic [AW-1:0] ai;
        for (int i = 0; i <= int'(len); i++) begin
            ai = a + AW'(i);
            sb.push_back('{last: (i == int'(len)), data: exp_mem[ai]});
        end
        if (stall > 0) bus.rsp_ready = 1'b0;
        send_req(1'b0, a, len);
        if (stall > 0) begin
            wait_sig(2, "rsp_valid_wait");
            repeat (stall) begin @(posedge clk); #1; end
            check("stall_held_data", bus.rsp_data, exp_mem[a]);
            bus.rsp_ready = 1'b1;
        end
        begin
            int n = 0;
            while (sb.size() != 0 && n < BOUND) begin
                @(posedge clk); #1; n++;
            end
            check("rd_drain", {31'd0, n < BOUND}, 32'd1);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [LENW-1:0] len,
                            input logic [DW-1:0] d [8], input int gap);
        int w0 = wr_dones;
        int n  = 0;
        send_req(1'b1, a, len);
        for (int i = 0; i <= int'(len); i++) begin
            wait_sig(1, "wd_ready_wait");
            if (i > 0) begin
                repeat (gap) begin @(posedge clk); #1; end
            end
            bus.wd_valid = 1'b1;
            bus.wd_data  = d[i];
            @(posedge clk); #1;
            bus.wd_valid = 1'b0;
            exp_mem[a + AW'(i)] = d[i];
        end
        while (wr_dones == w0 && n < BOUND) begin
            @(posedge clk); #1; n++;
        end
        check("wr_done_wait", {31'd0, n < BOUND}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] wd [8];
        int s0, w0, n;

        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
        bus.wd_valid  = 1'b0; bus.wd_data   = '0;   bus.rsp_ready = 1'b1;
        for (int k = 0; k < 32; k++) exp_mem[k] = DW'(k);
        for (int k = 0; k < 8; k++) wd[k] = '0;

        // reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_mem_read",  {31'd0, bus.mem_read},  32'd1);
        check("rst_mem_addr",  {27'd0, bus.mem_address}, 32'd0);
        check("rst_mem_in",    bus.mem_in,             32'd0);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_wd_ready",  {31'd0, bus.wd_ready},  32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_wr_done",   {31'd0, bus.wr_done},   32'd0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single read, no strobe expected
        s0 = strobes;
        do_read(5'd5, 3'd0, 0);
        check("t1_no_strobe", strobes - s0, 32'd0);

        // wrapping burst read 30,31,0,1
        do_read(5'd30, 3'd3, 0);

        // response stalled 5 cycles on beat 0
        do_read(5'd2, 3'd1, 5);
        check("t3_no_strobe", strobes - s0, 32'd0);

        // wrapping write burst with a 3-cycle data gap
        s0 = strobes; w0 = wr_dones;
        wd[0] = 32'hA5A5A5A5; wd[1] = 32'h5A5A5A5A;
        do_write(5'd31, 3'd1, wd, 3);
        repeat (3) begin @(posedge clk); #1; end
        check("t4_mem31",   mem[31], 32'hA5A5A5A5);
        check("t4_mem0",    mem[0],  32'h5A5A5A5A);
        check("t4_strobes", strobes - s0, 32'd2);
        check("t4_wr_done", wr_dones - w0, 32'd1);
        do_read(5'd31, 3'd1, 0);

        // reset during setup of beat 2 of a 4-beat write
        s0 = strobes;
        send_req(1'b1, 5'd10, 3'd3);
        wait_sig(1, "t5_wd_ready0");
        bus.wd_valid = 1'b1; bus.wd_data = 32'hDEAD0000;
        @(posedge clk); #1;
        bus.wd_valid = 1'b0;
        n = 0;
        while (strobes == s0 && n < BOUND) begin @(posedge clk); #1; n++; end
        check("t5_strobe1_wait", {31'd0, n < BOUND}, 32'd1);
        wait_sig(1, "t5_wd_ready1");
        bus.wd_valid = 1'b1; bus.wd_data = 32'hDEAD0001;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_mem_read", {31'd0, bus.mem_read}, 32'd1);
        check("t5_rst_wd_ready", {31'd0, bus.wd_ready}, 32'd0);
        bus.wd_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        exp_mem[10] = 32'hDEAD0000;
        check("t5_strobes",  strobes - s0, 32'd1);
        check("t5_mem10",    mem[10], 32'hDEAD0000);
        check("t5_mem11",    mem[11], 32'd11);
        check("t5_idle",     {31'd0, bus.req_ready}, 32'd1);

        // write then read back
        wd[0] = 32'h00001234;
        do_write(5'd7, 3'd0, wd, 0);
        do_read(5'd7, 3'd0, 0);
        do_read(5'd10, 3'd1, 0);

        repeat (5) begin @(posedge clk); #1; end
        check("no_extra_beats", extra_beats, 32'd0);
        check("sb_empty",       sb.size(),   32'd0);
        check("write_stable",   viol_stable, 32'd0);
        check("rsp_hold",       viol_hold,   32'd0);
        check("done_vs_valid",  viol_excl,   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
